lake_config_sequencer: RTL and testbench



---
 rtl/lake_config_sequencer.sv | 153 +++++++++++++++
 tb/tb_lake_config_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lake_config_sequencer.sv
// Configuration loader for a lakespec memory: narrow word writes fill a shadow
// register, and a commit sequences stall/flush around the copy to the active vector.
module lake_config_sequencer #(
   parameter int  CONFIG_MEMORY_SIZE = 512,
   parameter int  CFG_DATA_WIDTH     = 32,
   parameter int  STALL_PRE          = 2,
   parameter int  FLUSH_CYCLES       = 2,
   parameter int  DRAIN_CYCLES       = 2,
   localparam int NUM_WORDS = (CONFIG_MEMORY_SIZE + CFG_DATA_WIDTH - 1) / CFG_DATA_WIDTH,
   localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [ADDR_W-1:0]             cfg_addr,
   input  logic [CFG_DATA_WIDTH-1:0]     cfg_data,
   input  logic                          cfg_commit,
   output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
   output logic                          stall,
   output logic                          flush,
   output logic                          busy,
   output logic                          configured,
   output logic                          cfg_err
);

   localparam int SHADOW_W = NUM_WORDS * CFG_DATA_WIDTH;
   localparam int CNT_MAX  = (STALL_PRE > FLUSH_CYCLES)
                             ? ((STALL_PRE > DRAIN_CYCLES) ? STALL_PRE : DRAIN_CYCLES)
                             : ((FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES);
   localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_LOAD,
      ST_FLUSH,
      ST_DRAIN
   } state_t;

   state_t                          state, state_d;
   logic [CNT_W-1:0]                cnt, cnt_d;
   logic                            load_copy;
   logic                            stall_d, flush_d, busy_d, configured_d;
   logic [CONFIG_MEMORY_SIZE-1:0]   shadow, shadow_d;
   logic [SHADOW_W-1:0]             padded;
   logic                            wr_accept, addr_ok;

   assign cfg_ready = (state == ST_IDLE);
   assign wr_accept = cfg_valid & cfg_ready;
   assign addr_ok   = (int'(cfg_addr) < NUM_WORDS);

   // The write lands in a word-aligned image; bits past the vector width fall off here.
   always_comb begin
      padded = SHADOW_W'(shadow);
      if (addr_ok) padded[int'(cfg_addr)*CFG_DATA_WIDTH +: CFG_DATA_WIDTH] = cfg_data;
      shadow_d = padded[CONFIG_MEMORY_SIZE-1:0];
   end

   // State register plus the registered outputs and datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shadow is a plain register, not a RAM, so it takes the async reset like any other flop.
         state         <= ST_IDLE;
         cnt           <= '0;
         shadow        <= '0;
         config_memory <= '0;
         stall         <= 1'b1;
         flush         <= 1'b0;
         busy          <= 1'b0;
         configured    <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
         state      <= state_d;
         cnt        <= cnt_d;
         stall      <= stall_d;
         flush      <= flush_d;
         busy       <= busy_d;
         configured <= configured_d;
         if (wr_accept) begin
            if (addr_ok) shadow  <= shadow_d;
            else         cfg_err <= 1'b1;
         end
         if (load_copy) config_memory <= shadow;
      end
   end

   // Next-state and counter.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch behind.
      state_d      = state;
      cnt_d        = cnt;
      load_copy    = 1'b0;
      configured_d = configured;
      unique case (state)
         ST_IDLE: begin
            if (cfg_commit) begin
               state_d = ST_PRE;
               cnt_d   = CNT_W'(STALL_PRE - 1);
            end
         end
         ST_PRE: begin
            if (cnt == '0) state_d = ST_LOAD;
            else           cnt_d   = cnt - CNT_W'(1);
         end
         ST_LOAD: begin
            load_copy = 1'b1;
            state_d   = ST_FLUSH;
            cnt_d     = CNT_W'(FLUSH_CYCLES - 1);
         end
         ST_FLUSH: begin
            if (cnt == '0) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               state_d      = ST_IDLE;
               configured_d = 1'b1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so the flops show the value of that state.
   always_comb begin
      stall_d = 1'b1;
      flush_d = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      unique case (state_d)
         ST_IDLE:  stall_d = ~configured_d;
         ST_PRE,
         ST_LOAD:  stall_d = 1'b1;
         ST_FLUSH: begin
            stall_d = 1'b1;
            flush_d = 1'b1;
         end
         ST_DRAIN: begin
            stall_d = 1'b0;
            flush_d = 1'b1;
         end
         default:  stall_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_lake_config_sequencer.sv
// Bench for lake_config_sequencer: three widths share one stimulus stream and are
// compared every cycle against a timeline model, plus directed spot checks.
module tb_lake_config_sequencer;

   localparam int SP    = 2;
   localparam int FC    = 2;
   localparam int DC    = 2;
   localparam int TOTAL = SP + 1 + FC + DC;
   localparam int SZ [3] = '{512, 500, 464};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid, cfg_commit;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;

   logic        ready_a, ready_b, ready_c;
   logic        stall_a, stall_b, stall_c;
   logic        flush_a, flush_b, flush_c;
   logic        busy_a, busy_b, busy_c;
   logic        conf_a, conf_b, conf_c;
   logic        err_a, err_b, err_c;
   logic [511:0] cm_a;
   logic [499:0] cm_b;
   logic [463:0] cm_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lake_config_sequencer #(.CONFIG_MEMORY_SIZE(512)) dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .config_memory(cm_a), .stall(stall_a), .flush(flush_a), .busy(busy_a),
      .configured(conf_a), .cfg_err(err_a));

   lake_config_sequencer #(.CONFIG_MEMORY_SIZE(500)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .config_memory(cm_b), .stall(stall_b), .flush(flush_b), .busy(busy_b),
      .configured(conf_b), .cfg_err(err_b));

   lake_config_sequencer #(.CONFIG_MEMORY_SIZE(464)) dut_c (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_c),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .config_memory(cm_c), .stall(stall_c), .flush(flush_c), .busy(busy_c),
      .configured(conf_c), .cfg_err(err_c));

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: position within the commit timeline (0 = idle) plus per-width images.
   int           pos;
   logic         configured_m;
   logic [511:0] shadow_m [3];
   logic [511:0] active_m [3];
   logic         err_m [3];

   function automatic logic [511:0] width_mask(input int sz);
      return {512{1'b1}} >> (512 - sz);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos          = 0;
         configured_m = 1'b0;
         for (int k = 0; k < 3; k++) begin
            shadow_m[k] = '0;
            active_m[k] = '0;
            err_m[k]    = 1'b0;
         end
      end else if (pos == 0) begin
         if (cfg_valid) begin
            for (int k = 0; k < 3; k++) begin
               if (int'(cfg_addr) < (SZ[k] + 31) / 32) begin
                  shadow_m[k][int'(cfg_addr)*32 +: 32] = cfg_data;
                  shadow_m[k] = shadow_m[k] & width_mask(SZ[k]);
               end else begin
                  err_m[k] = 1'b1;
               end
            end
         end
         if (cfg_commit) pos = 1;
      end else begin
         if (pos == SP + 1)
            for (int k = 0; k < 3; k++) active_m[k] = shadow_m[k];
         if (pos == TOTAL) begin
            pos          = 0;
            configured_m = 1'b1;
         end else begin
            pos++;
         end
      end
   end

   // Every-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_stall, exp_flush;
         exp_stall = (pos > 0) ? (pos <= SP + 1 + FC) : ~configured_m;
         exp_flush = (pos > SP + 1);
         check("stall",      512'({stall_a, stall_b, stall_c}), 512'({3{exp_stall}}));
         check("flush",      512'({flush_a, flush_b, flush_c}), 512'({3{exp_flush}}));
         check("busy",       512'({busy_a, busy_b, busy_c}),    512'({3{pos > 0}}));
         check("cfg_ready",  512'({ready_a, ready_b, ready_c}), 512'({3{pos == 0}}));
         check("configured", 512'({conf_a, conf_b, conf_c}),    512'({3{configured_m}}));
         check("cfg_err",    512'({err_a, err_b, err_c}),       512'({err_m[0], err_m[1], err_m[2]}));
         check("cm_512",     cm_a,        active_m[0]);
         check("cm_500",     512'(cm_b),  active_m[1]);
         check("cm_464",     512'(cm_c),  active_m[2]);
      end
   end

   task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d, input logic c);
      cfg_valid  = v;
      cfg_addr   = a;
      cfg_data   = d;
      cfg_commit = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      idle(5);
      check("rst_stall",  512'(stall_a), 512'(1));
      check("rst_flush",  512'(flush_a), 512'(0));
      check("rst_cm",     cm_a,          512'(0));
      check("rst_ready",  512'(ready_a), 512'(1));
      check("rst_conf",   512'(conf_a),  512'(0));

      // Fill all words, then commit; timeline offsets are relative to the commit edge N.
      for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 32'h1000_0000 + 32'(i), 1'b0);
      check("err_inrange", 512'(err_a), 512'(0));
      check("err_oor",     512'(err_c), 512'(1));
      drive(1'b0, 4'd0, 32'd0, 1'b1);
      idle(3);
      check("n4_lo",    512'(cm_a[31:0]),    512'(32'h1000_0000));
      check("n4_hi",    512'(cm_a[511:480]), 512'(32'h1000_000F));
      check("n4_b_top", 512'(cm_b[499:480]), 512'(20'h0000F));
      check("n4_flush", 512'(flush_a),       512'(1));
      idle(4);
      check("n8_conf",  512'(conf_a),  512'(1));
      check("n8_stall", 512'(stall_a), 512'(0));

      // Write alongside commit, then hold a write pending through the whole busy window.
      drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);
      for (int i = 0; i < TOTAL; i++) drive(1'b1, 4'd5, 32'hCAFE_0005, 1'b0);
      check("same_cycle_wr", 512'(cm_a[127:96]),  512'(32'hDEAD_BEEF));
      check("held_no_wr",    512'(cm_a[191:160]), 512'(32'h1000_0005));
      check("ready_back",    512'(ready_a),       512'(1));
      drive(1'b1, 4'd5, 32'hCAFE_0005, 1'b0);
      drive(1'b0, 4'd0, 32'd0, 1'b1);
      idle(TOTAL);
      check("pending_wr", 512'(cm_a[191:160]), 512'(32'hCAFE_0005));

      // Top-word truncation at 500 bits.
      drive(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1);
      idle(TOTAL);
      check("trunc_500", 512'(cm_b[499:480]), 512'(20'hFFFFF));

      // Random traffic, including commits while busy that must be ignored.
      repeat (400)
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 7) == 0);

      // Drain to idle (bounded), then reset in the middle of FLUSH.
      for (int i = 0; i < 2 * TOTAL && pos != 0; i++) idle(1);
      check("drain_idle", 512'(pos == 0), 512'(1));
      drive(1'b0, 4'd0, 32'd0, 1'b1);
      idle(SP + 1);
      check("in_flush", 512'(flush_a & stall_a), 512'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_flush", 512'(flush_a), 512'(0));
      check("arst_stall", 512'(stall_a), 512'(1));
      check("arst_cm",    cm_a,          512'(0));
      check("arst_conf",  512'(conf_a),  512'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(4);
      drive(1'b1, 4'd0, 32'h0000_00A5, 1'b1);
      idle(TOTAL);
      check("recover_cm", cm_a, 512'(32'h0000_00A5));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
